// File: rtl/debug_unit_pkg.sv
// -----------------------------------------------------------------------------
// debug_unit_pkg
// Shared definitions for the host-side debug controller:
//   - host command codes received over the UART link
//   - HALT_WORD, the instruction that terminates a program load
//   - FSM state encodings used by debug_unit
//   - word_byte(): selects one byte of a 32-bit word, MSB first
// -----------------------------------------------------------------------------
package debug_unit_pkg;

    // Host command bytes, only decoded while the controller is idle
    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_DUMP = 8'h04;

    // Instruction that marks end of program, both for the loader and the datapath
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // Controller FSM encodings
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD_BYTE  = 3'd1;
    localparam logic [2:0] ST_LOAD_WRITE = 3'd2;
    localparam logic [2:0] ST_RUN        = 3'd3;
    localparam logic [2:0] ST_STEP       = 3'd4;
    localparam logic [2:0] ST_DUMP_SEND  = 3'd5;
    localparam logic [2:0] ST_DUMP_WAIT  = 3'd6;

    // Byte idx 0 is the most significant byte of the word
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] sel;
        case (idx)
            2'd0:    sel = word[31:24];
            2'd1:    sel = word[23:16];
            2'd2:    sel = word[15:8];
            default: sel = word[7:0];
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/reg_dump_serializer.sv
// -----------------------------------------------------------------------------
// reg_dump_serializer
// Snapshots the register file on i_start and streams it out one byte at a
// time: reg0 first, MSB first within each register. Each byte is a single
// o_tx_start pulse; the next byte is only launched after i_tx_done.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   i_start      begin a dump (ignored while busy)
//   i_rf_regs    register file, reg0 in the low PROC_BITS bits
//   i_tx_done    transmitter finished the previous byte
//   o_busy       a dump is in progress
//   o_done       combinational: the last byte's i_tx_done is being accepted
//   o_tx_data    byte to transmit, held from its start pulse until i_tx_done
//   o_tx_start   registered one-cycle transmit request
// -----------------------------------------------------------------------------
module reg_dump_serializer
    import debug_unit_pkg::*;
#(
    parameter int PROC_BITS = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [NUM_REGS*PROC_BITS-1:0] i_rf_regs,
    input  logic                          i_tx_done,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_start
);

    localparam int REG_IDX_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [REG_IDX_BITS-1:0] LAST_REG = REG_IDX_BITS'(NUM_REGS - 1);

    logic [NUM_REGS-1:0][PROC_BITS-1:0] r_snap;
    logic [REG_IDX_BITS-1:0]            r_reg_idx;
    logic [1:0]                         r_byte_idx;
    logic                               r_busy;
    logic                               r_tx_start;
    logic [7:0]                         r_tx_data;

    logic                    w_accept_done;
    logic                    w_last_byte;
    logic                    w_advance;
    logic [1:0]              w_next_byte;
    logic [REG_IDX_BITS-1:0] w_next_reg;
    logic [PROC_BITS-1:0]    w_next_word;

    // A done strobe coinciding with the start pulse belongs to no byte yet
    assign w_accept_done = r_busy && !r_tx_start && i_tx_done;
    assign w_last_byte   = (r_reg_idx == LAST_REG) && (r_byte_idx == 2'd3);
    assign w_advance     = w_accept_done && !w_last_byte;

    // Byte index wraps 3 -> 0 and carries into the register index
    assign w_next_byte = r_byte_idx + 2'd1;
    assign w_next_reg  = (r_byte_idx == 2'd3) ? r_reg_idx + REG_IDX_BITS'(1) : r_reg_idx;
    assign w_next_word = r_snap[w_next_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap     <= '0;
            r_reg_idx  <= '0;
            r_byte_idx <= '0;
            r_busy     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            if (i_start && !r_busy) begin
                // First byte comes straight from the live inputs so the start
                // pulse can go out on the same edge that takes the snapshot.
                r_snap     <= i_rf_regs;
                r_reg_idx  <= '0;
                r_byte_idx <= '0;
                r_tx_data  <= word_byte(i_rf_regs[PROC_BITS-1:0], 2'd0);
                r_tx_start <= 1'b1;
                r_busy     <= 1'b1;
            end else if (w_advance) begin
                r_reg_idx  <= w_next_reg;
                r_byte_idx <= w_next_byte;
                r_tx_data  <= word_byte(w_next_word, w_next_byte);
                r_tx_start <= 1'b1;
            end else if (w_accept_done) begin
                r_busy     <= 1'b0;
                r_reg_idx  <= '0;
                r_byte_idx <= '0;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = w_accept_done && w_last_byte;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;

endmodule

// File: rtl/debug_unit.sv
// -----------------------------------------------------------------------------
// debug_unit
// Host-side debug controller between the UART byte links and the datapath.
// Decodes host commands, assembles 4-byte instructions (MSB first) into
// instruction-memory writes, gates the datapath enable for run/step, and
// hands register-file dumps to reg_dump_serializer.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_rx_data/done    received byte and its one-cycle valid strobe
//   i_tx_done         transmitter finished the previous byte
//   i_halt            datapath retired HALT
//   i_rf_regs         register file, reg0 in the low bits
//   o_tx_data/start   byte to send and its one-cycle request
//   o_write_inst_mem  one-cycle instruction-memory write strobe
//   o_inst_mem_addr   write address (word index)
//   o_inst_mem_data   write data
//   o_enable          datapath clock enable
// -----------------------------------------------------------------------------
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int PC_BITS          = 32,
    parameter int INSTRUCTION_BITS = 32,
    parameter int PROC_BITS        = 32,
    parameter int NUM_REGS         = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_done,
    input  logic                          i_tx_done,
    input  logic                          i_halt,
    input  logic [NUM_REGS*PROC_BITS-1:0] i_rf_regs,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_start,
    output logic                          o_write_inst_mem,
    output logic [PC_BITS-1:0]            o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0]   o_inst_mem_data,
    output logic                          o_enable
);

    logic [2:0]                  r_state;
    logic [1:0]                  r_byte_cnt;
    logic [INSTRUCTION_BITS-9:0] r_word;      // the up-to-3 bytes already received
    logic [PC_BITS-1:0]          r_addr;
    logic                        r_write;
    logic [INSTRUCTION_BITS-1:0] r_inst_data;
    logic                        r_enable;

    logic                        w_dump_start;
    logic                        w_ser_busy;
    logic                        w_ser_done;
    logic [INSTRUCTION_BITS-1:0] w_assembled;

    assign w_assembled = {r_word, i_rx_data};

    // A dump starts on the edge that leaves STEP, the edge that sees HALT in
    // RUN, or the edge that decodes an explicit DUMP command.
    assign w_dump_start = (r_state == ST_STEP)
                       || (r_state == ST_RUN && i_halt)
                       || (r_state == ST_IDLE && i_rx_done && i_rx_data == CMD_DUMP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_inst_data <= '0;
            r_enable    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                r_state    <= ST_LOAD_BYTE;
                                r_addr     <= '0;
                                r_byte_cnt <= '0;
                            end
                            CMD_RUN: begin
                                r_state  <= ST_RUN;
                                r_enable <= 1'b1;
                            end
                            CMD_STEP: begin
                                r_state  <= ST_STEP;
                                r_enable <= 1'b1;
                            end
                            CMD_DUMP: r_state <= ST_DUMP_SEND;
                            default:  r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_LOAD_BYTE: begin
                    if (i_rx_done) begin
                        r_word     <= w_assembled[INSTRUCTION_BITS-9:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_inst_data <= w_assembled;
                            r_write     <= 1'b1;
                            r_state     <= ST_LOAD_WRITE;
                        end
                    end
                end
                ST_LOAD_WRITE: begin
                    // Any rx strobe here is dropped; the word being written is final
                    r_write <= 1'b0;
                    r_addr  <= r_addr + PC_BITS'(1);
                    r_state <= (r_inst_data == HALT_WORD) ? ST_IDLE : ST_LOAD_BYTE;
                end
                ST_RUN: begin
                    if (i_halt) begin
                        r_enable <= 1'b0;
                        r_state  <= ST_DUMP_SEND;
                    end
                end
                ST_STEP: begin
                    r_enable <= 1'b0;
                    r_state  <= ST_DUMP_SEND;
                end
                ST_DUMP_SEND: begin
                    // The serializer's start pulse is visible during this state
                    r_state <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    if (w_ser_done || !w_ser_busy) begin
                        r_state <= ST_IDLE;
                    end else if (i_tx_done) begin
                        r_state <= ST_DUMP_SEND;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_write  <= 1'b0;
                    r_enable <= 1'b0;
                end
            endcase
        end
    end

    reg_dump_serializer #(
        .PROC_BITS (PROC_BITS),
        .NUM_REGS  (NUM_REGS)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_dump_start),
        .i_rf_regs  (i_rf_regs),
        .i_tx_done  (i_tx_done),
        .o_busy     (w_ser_busy),
        .o_done     (w_ser_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start)
    );

    assign o_write_inst_mem = r_write;
    assign o_inst_mem_addr  = r_addr;
    assign o_inst_mem_data  = r_inst_data;
    assign o_enable         = r_enable;

endmodule

// File: tb/tb_debug_unit.sv
// -----------------------------------------------------------------------------
// tb_debug_unit
// Directed stimulus for debug_unit with a scoreboard: expected instruction
// writes and transmitted bytes are queued as stimulus is driven and compared
// as the DUT produces them. A simple transmitter model returns i_tx_done a
// few cycles after each o_tx_start.
// -----------------------------------------------------------------------------
module tb_debug_unit;
    import debug_unit_pkg::*;

    localparam int PC_BITS          = 32;
    localparam int INSTRUCTION_BITS = 32;
    localparam int PROC_BITS        = 32;
    localparam int NUM_REGS         = 32;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [7:0]                    i_rx_data = '0;
    logic                          i_rx_done = 1'b0;
    logic                          i_tx_done = 1'b0;
    logic                          i_halt = 1'b0;
    logic [NUM_REGS*PROC_BITS-1:0] i_rf_regs = '0;
    logic [7:0]                    o_tx_data;
    logic                          o_tx_start;
    logic                          o_write_inst_mem;
    logic [PC_BITS-1:0]            o_inst_mem_addr;
    logic [INSTRUCTION_BITS-1:0]   o_inst_mem_data;
    logic                          o_enable;

    debug_unit #(
        .PC_BITS          (PC_BITS),
        .INSTRUCTION_BITS (INSTRUCTION_BITS),
        .PROC_BITS        (PROC_BITS),
        .NUM_REGS         (NUM_REGS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_rx_data        (i_rx_data),
        .i_rx_done        (i_rx_done),
        .i_tx_done        (i_tx_done),
        .i_halt           (i_halt),
        .i_rf_regs        (i_rf_regs),
        .o_tx_data        (o_tx_data),
        .o_tx_start       (o_tx_start),
        .o_write_inst_mem (o_write_inst_mem),
        .o_inst_mem_addr  (o_inst_mem_addr),
        .o_inst_mem_data  (o_inst_mem_data),
        .o_enable         (o_enable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];
    int         en_cycles = 0;
    int         tx_count  = 0;
    int         wr_count  = 0;

    logic [31:0] model_regs [NUM_REGS];
    logic [7:0]  load_a [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0]  load_b [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor (samples on falling edge) ----------
    wr_t        mon_wr;
    logic [7:0] mon_tx;
    always @(negedge clk) begin
        if (rst) begin
            if (o_enable) en_cycles++;
            if (o_write_inst_mem) begin
                wr_count++;
                $display("write addr=%0h data=%08h", o_inst_mem_addr, o_inst_mem_data);
                check("write_with_enable", o_enable, 0);
                check("write_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    mon_wr = wr_q.pop_front();
                    check("write_addr", o_inst_mem_addr, mon_wr.addr);
                    check("write_data", o_inst_mem_data, mon_wr.data);
                end
            end
            if (o_tx_start) begin
                tx_count++;
                $display("tx byte=%02h", o_tx_data);
                check("tx_expected", tx_q.size() != 0, 1);
                if (tx_q.size() != 0) begin
                    mon_tx = tx_q.pop_front();
                    check("tx_byte", o_tx_data, mon_tx);
                end
            end
        end
    end

    // ---------------- transmitter model: done 3 cycles after start ----------
    int tx_delay = -1;
    always @(negedge clk) begin
        i_tx_done = 1'b0;
        if (!rst) begin
            tx_delay = -1;
        end else begin
            if (tx_delay == 0) begin
                i_tx_done = 1'b1;
                tx_delay  = -1;
            end else if (tx_delay > 0) begin
                tx_delay--;
            end
            if (o_tx_start) tx_delay = 1;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic apply_regs_and_expect_dump();
        for (int r = 0; r < NUM_REGS; r++) begin
            i_rf_regs[r*PROC_BITS +: PROC_BITS] = model_regs[r];
            tx_q.push_back(model_regs[r][31:24]);
            tx_q.push_back(model_regs[r][23:16]);
            tx_q.push_back(model_regs[r][15:8]);
            tx_q.push_back(model_regs[r][7:0]);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((tx_q.size() != 0 || wr_q.size() != 0 || dut.r_state != ST_IDLE) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_time"}, n < budget, 1);
        check({tag, "_idle"}, dut.r_state, ST_IDLE);
        check({tag, "_drained"}, tx_q.size() + wr_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_start"}, o_tx_start, 0);
        check({tag, "_tx_data"}, o_tx_data, 0);
        check({tag, "_write"}, o_write_inst_mem, 0);
        check({tag, "_addr"}, o_inst_mem_addr, 0);
        check({tag, "_data"}, o_inst_mem_data, 0);
        check({tag, "_enable"}, o_enable, 0);
        check({tag, "_state"}, dut.r_state, ST_IDLE);
    endtask

    // ---------------- directed sequence --------------------------------------
    int base_en, base_tx, base_wr;
    initial begin
        tick(3);
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick(2);

        // LOAD of two words, second is HALT
        base_en = en_cycles; base_wr = wr_count;
        push_wr(32'd0, 32'h2008_0005);
        push_wr(32'd1, 32'hFFFF_FFFF);
        send_byte(CMD_LOAD); tick(2);
        for (int i = 0; i < 8; i++) begin
            send_byte(load_a[i]); tick(2);
        end
        wait_idle("load", 60);
        check("load_writes", wr_count - base_wr, 2);
        check("load_enable", en_cycles - base_en, 0);

        // STEP: one enable cycle, then dump starting the following cycle
        for (int r = 0; r < NUM_REGS; r++) model_regs[r] = 32'h0;
        model_regs[1] = 32'h1122_3344;
        apply_regs_and_expect_dump();
        base_en = en_cycles; base_tx = tx_count;
        send_byte(CMD_STEP);
        check("step_enable_on", o_enable, 1);
        @(negedge clk);
        check("step_enable_off", o_enable, 0);
        check("step_first_tx", o_tx_start, 1);
        wait_idle("step", 1000);
        check("step_enable_cycles", en_cycles - base_en, 1);
        check("step_tx_count", tx_count - base_tx, 128);

        // RUN, halt 50 cycles later; inputs change after the snapshot edge
        for (int r = 0; r < NUM_REGS; r++) model_regs[r] = 32'h9E37_79B9 * (r + 1);
        apply_regs_and_expect_dump();
        base_en = en_cycles; base_tx = tx_count;
        send_byte(CMD_RUN);
        tick(49);
        i_halt = 1'b1;
        @(negedge clk);
        i_halt = 1'b0;
        i_rf_regs = '1;
        check("run_enable_dropped", o_enable, 0);
        wait_idle("run", 1000);
        check("run_enable_cycles", en_cycles - base_en, 50);
        check("run_tx_count", tx_count - base_tx, 128);

        // Unknown command, then explicit DUMP with rx traffic during it
        base_en = en_cycles; base_tx = tx_count; base_wr = wr_count;
        send_byte(8'h7E); tick(2);
        check("unknown_idle", dut.r_state, ST_IDLE);
        for (int r = 0; r < NUM_REGS; r++) model_regs[r] = {8'(r), 8'hA5, 8'(~r), 8'h3C};
        apply_regs_and_expect_dump();
        send_byte(CMD_DUMP); tick(3);
        send_byte(CMD_LOAD); tick(3);
        send_byte(CMD_STEP); tick(3);
        send_byte(CMD_RUN);
        wait_idle("dump", 1000);
        check("dump_tx_count", tx_count - base_tx, 128);
        check("dump_no_writes", wr_count - base_wr, 0);
        check("dump_no_enable", en_cycles - base_en, 0);

        // Reset after two LOAD bytes, then a fresh load from address 0
        send_byte(CMD_LOAD); tick(2);
        send_byte(8'hAA); tick(2);
        send_byte(8'hBB); tick(1);
        #2 rst = 1'b0;
        #1 check_outputs_zero("rst_load");
        @(negedge clk);
        rst = 1'b1;
        push_wr(32'd0, 32'h1234_5678);
        push_wr(32'd1, 32'hFFFF_FFFF);
        send_byte(CMD_LOAD); tick(2);
        for (int i = 0; i < 8; i++) begin
            send_byte(load_b[i]); tick(2);
        end
        wait_idle("reload", 60);

        // Rx strobe held into the LOAD_WRITE cycle must be dropped
        push_wr(32'd0, 32'hCAFE_F00D);
        push_wr(32'd1, 32'hFFFF_FFFF);
        send_byte(CMD_LOAD); tick(2);
        send_byte(8'hCA); tick(2);
        send_byte(8'hFE); tick(2);
        send_byte(8'hF0); tick(2);
        @(negedge clk);
        i_rx_data = 8'h0D;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_data = 8'h5A;
        check("collide_write_cycle", o_write_inst_mem, 1);
        @(negedge clk);
        i_rx_done = 1'b0;
        tick(2);
        for (int i = 4; i < 8; i++) begin
            send_byte(load_a[i]); tick(2);
        end
        wait_idle("collide", 60);

        // Reset in the middle of a dump: no strobes afterwards
        for (int r = 0; r < NUM_REGS; r++) model_regs[r] = 32'h5555_0000 + r;
        apply_regs_and_expect_dump();
        send_byte(CMD_DUMP);
        tick(30);
        #2 rst = 1'b0;
        tx_q.delete();
        #1 check_outputs_zero("rst_dump");
        @(negedge clk);
        rst = 1'b1;
        base_tx = tx_count;
        tick(40);
        check("rst_dump_silent", tx_count - base_tx, 0);
        check("rst_dump_idle", dut.r_state, ST_IDLE);

        check("final_queues", tx_q.size() + wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
